sec_an_loc_search: RTL and testbench

- Sequential front end of the product (AN) code single-error corrector, with A = 1939 and 8-bit data.
- Accepts a received 19-bit codeword and computes its residue mod A by serial restoring reduction.
- If the residue is non-zero, searches error locations ±1..±19 against the l-LUT remainders.
- Emits the corrected codeword, the signed error location and a status code to the downstream divide/decode stage.

---
 rtl/sec_an_pkg.sv | 22 ++
 rtl/sec_an_loc_search_if.sv | 19 +
 rtl/SEC_lLUT8bits.sv | 44 ++++
 rtl/sec_an_loc_search.sv | 128 ++++++++++++
 tb/tb_sec_an_loc_search.sv | 136 +++++++++++++
 5 files changed

// File: rtl/sec_an_pkg.sv
// Shared constants, status codes and FSM states for the AN-code single-error
// location search front end (A = 1939, 8-bit data).
package sec_an_pkg;
    localparam int A      = 1939;
    localparam int CW_W   = 19;
    localparam int R_W    = 11;
    localparam int L_W    = 6;
    localparam int CW_MAX = 494445;

    typedef enum logic [1:0] {
        ST_CLEAN = 2'd0,
        ST_CORR  = 2'd1,
        ST_UNC   = 2'd2
    } status_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESIDUE = 2'd1,
        SEARCH  = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/sec_an_loc_search_if.sv
// Codeword in / result out handshake bundle between the search front end and
// its producer and consumer.
interface sec_an_loc_search_if;
    import sec_an_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [CW_W-1:0]       in_cw;
    logic                  out_valid;
    logic                  out_ready;
    logic [CW_W-1:0]       out_cw;
    logic signed [L_W-1:0] out_loc;
    logic [1:0]            out_status;

    modport slave  (input  in_valid, in_cw, out_ready,
                    output in_ready, out_valid, out_cw, out_loc, out_status);
    modport master (output in_valid, in_cw, out_ready,
                    input  in_ready, out_valid, out_cw, out_loc, out_status);
endinterface

// File: rtl/SEC_lLUT8bits.sv
// l-LUT: remainder mod A of the error pattern +/-2^(|l|-1) for |l| = 1..19.
// Out-of-range l returns 0, which never equals a non-zero search residue.
module SEC_lLUT8bits
    import sec_an_pkg::*;
(
    input  logic signed [L_W-1:0] l,
    output logic [R_W-1:0]        r
);
    logic [L_W-1:0] mag;
    logic [R_W-1:0] m;

    always_comb begin
        mag = l[L_W-1] ? L_W'(-l) : l;
        case (mag)
            6'd1:  m = 11'd1;
            6'd2:  m = 11'd2;
            6'd3:  m = 11'd4;
            6'd4:  m = 11'd8;
            6'd5:  m = 11'd16;
            6'd6:  m = 11'd32;
            6'd7:  m = 11'd64;
            6'd8:  m = 11'd128;
            6'd9:  m = 11'd256;
            6'd10: m = 11'd512;
            6'd11: m = 11'd1024;
            6'd12: m = 11'd109;
            6'd13: m = 11'd218;
            6'd14: m = 11'd436;
            6'd15: m = 11'd872;
            6'd16: m = 11'd1744;
            6'd17: m = 11'd1549;
            6'd18: m = 11'd1159;
            6'd19: m = 11'd379;
            default: m = '0;
        endcase
        // -2^k mod A is A minus the positive remainder (never zero here)
        if (m == '0)
            r = '0;
        else if (l[L_W-1])
            r = R_W'(A) - m;
        else
            r = m;
    end
endmodule

// File: rtl/sec_an_loc_search.sv
// Serial residue mod A followed by a +/-l error location search; hands the
// corrected codeword, signed location and status to the decode stage.
module sec_an_loc_search
    import sec_an_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    sec_an_loc_search_if.slave    bus
);
    state_t                state, state_nx;
    logic [CW_W-1:0]       y, y_nx;
    logic [R_W-1:0]        rem, rem_nx, red;
    logic [4:0]            idx, idx_nx;
    logic [4:0]            l, l_nx;
    logic [CW_W-1:0]       cw_q, cw_nx;
    logic signed [L_W-1:0] loc_q, loc_nx;
    logic [1:0]            st_q, st_nx;

    logic [R_W:0]          t;
    logic signed [L_W-1:0] lp, ln;
    logic [R_W-1:0]        rp, rn;
    logic [CW_W:0]         pow, cp, cn, cand;
    logic                  hit;
    logic signed [L_W-1:0] hit_loc;

    SEC_lLUT8bits u_lut_p (.l(lp), .r(rp));
    SEC_lLUT8bits u_lut_n (.l(ln), .r(rn));

    assign t   = {rem, y[idx]};
    assign red = (t >= (R_W+1)'(A)) ? R_W'(t - (R_W+1)'(A)) : t[R_W-1:0];
    assign lp  = {1'b0, l};
    assign ln  = -lp;
    assign pow = (CW_W+1)'(1) << (l - 5'd1);
    // 20-bit two's complement: bit 19 set means the candidate went negative
    assign cp  = {1'b0, y} - pow;
    assign cn  = {1'b0, y} + pow;

    assign bus.in_ready   = (state == IDLE) && rst_n;
    assign bus.out_valid  = (state == DONE);
    assign bus.out_cw     = cw_q;
    assign bus.out_loc    = loc_q;
    assign bus.out_status = st_q;

    always_comb begin
        state_nx = state;
        y_nx     = y;
        rem_nx   = rem;
        idx_nx   = idx;
        l_nx     = l;
        cw_nx    = cw_q;
        loc_nx   = loc_q;
        st_nx    = st_q;
        hit      = 1'b0;
        hit_loc  = '0;
        cand     = '0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    y_nx     = bus.in_cw;
                    rem_nx   = '0;
                    idx_nx   = 5'd18;
                    state_nx = RESIDUE;
                end
            end
            RESIDUE: begin
                rem_nx = red;
                idx_nx = idx - 5'd1;
                if (idx == 5'd0) begin
                    if (red == '0) begin
                        cw_nx    = y;
                        loc_nx   = '0;
                        st_nx    = ST_CLEAN;
                        state_nx = DONE;
                    end else begin
                        l_nx     = 5'd1;
                        state_nx = SEARCH;
                    end
                end
            end
            SEARCH: begin
                l_nx = l + 5'd1;
                if (rem == rp) begin
                    hit = 1'b1; hit_loc = lp; cand = cp;
                end else if (rem == rn) begin
                    hit = 1'b1; hit_loc = ln; cand = cn;
                end
                if (hit && !cand[CW_W] && (cand[CW_W-1:0] <= CW_W'(CW_MAX))) begin
                    cw_nx    = cand[CW_W-1:0];
                    loc_nx   = hit_loc;
                    st_nx    = ST_CORR;
                    state_nx = DONE;
                end else if (hit || (l == 5'd19)) begin
                    cw_nx    = y;
                    loc_nx   = '0;
                    st_nx    = ST_UNC;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            y     <= '0;
            rem   <= '0;
            idx   <= '0;
            l     <= '0;
            cw_q  <= '0;
            loc_q <= '0;
            st_q  <= '0;
        end else begin
            state <= state_nx;
            y     <= y_nx;
            rem   <= rem_nx;
            idx   <= idx_nx;
            l     <= l_nx;
            cw_q  <= cw_nx;
            loc_q <= loc_nx;
            st_q  <= st_nx;
        end
    end
endmodule

// File: tb/tb_sec_an_loc_search.sv
// Directed bench for sec_an_loc_search: arithmetic reference model, literal
// expectations for each vector, and a per-cycle output compare process.
module tb_sec_an_loc_search;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cw = 0, exp_loc = 0, exp_st = 0;

    sec_an_loc_search_if bus();

    sec_an_loc_search dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: residue by %, then try every single-bit error +/-2^(k-1)
    task automatic model(input int cw, output int ecw, output int eloc,
                         output int est, output int lat);
        int r, p, c;
        bit found;
        r = cw % 1939;
        ecw = cw; eloc = 0; est = 2; lat = 38; found = 0;
        if (r == 0) begin
            est = 0; lat = 19;
        end else begin
            for (int k = 1; k <= 19 && !found; k++) begin
                p = (1 << (k - 1)) % 1939;
                if (r == p || r == 1939 - p) begin
                    found = 1;
                    lat = 19 + k;
                    c = (r == p) ? cw - (1 << (k - 1)) : cw + (1 << (k - 1));
                    if (c >= 0 && c <= 255 * 1939) begin
                        ecw = c; eloc = (r == p) ? k : -k; est = 1;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            chk("out_cw", int'(bus.out_cw), exp_cw);
            chk("out_loc", int'(bus.out_loc), exp_loc);
            chk("out_status", int'(bus.out_status), exp_st);
            chk("in_ready_in_done", int'(bus.in_ready), 0);
        end
    end

    task automatic send(input int cw, input int lcw, input int lloc,
                        input int lst, input int llat, input int hold);
        int ecw, eloc, est, lat, n;
        model(cw, ecw, eloc, est, lat);
        chk("model_cw", ecw, lcw);
        chk("model_loc", eloc, lloc);
        chk("model_status", est, lst);
        chk("model_latency", lat, llat);
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("in_ready_idle", int'(bus.in_ready), 1);
        exp_cw = ecw; exp_loc = eloc; exp_st = est;
        bus.in_valid = 1'b1;
        bus.in_cw = 19'(cw);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 60) begin @(posedge clk); #1; n++; end
        chk("latency", n, lat);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            bus.in_valid = 1'b1;
            bus.in_cw = 19'd12345;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        chk("handoff_valid", int'(bus.out_valid), 0);
        chk("handoff_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_cw = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_cw", int'(bus.out_cw), 0);
        chk("rst_out_loc", int'(bus.out_loc), 0);
        chk("rst_out_status", int'(bus.out_status), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", int'(bus.in_ready), 1);

        send(193900, 193900, 0, 0, 19, 0);
        send(193916, 193900, 5, 1, 24, 0);
        send(193899, 193900, -1, 1, 20, 0);
        send(3, 3, 0, 2, 38, 0);
        send(524287, 524287, 0, 2, 38, 0);
        send(109, 109, 0, 2, 31, 0);
        send(496383, 496383, 0, 2, 20, 0);
        send(193916, 193900, 5, 1, 24, 5);
        send(193900, 193900, 0, 0, 19, 0);
        send(193899, 193900, -1, 1, 20, 0);

        // reset while searching for the +5 location
        bus.in_valid = 1'b1;
        bus.in_cw = 19'd193916;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (21) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_out_cw", int'(bus.out_cw), 0);
        chk("midrst_out_loc", int'(bus.out_loc), 0);
        chk("midrst_out_status", int'(bus.out_status), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle", int'(bus.in_ready), 1);
        send(193900, 193900, 0, 0, 19, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
